button_event_decoder: RTL and testbench

//   Consumes a clean, debounced button level and classifies each gesture as SHORT, LONG or

---
 rtl/button_event_decoder.sv | 133 +++++++++++++
 tb/tb_button_event_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures as SHORT, LONG or DOUBLE press and
// presents one event code per gesture through a single-entry valid/ready register.
module button_event_decoder #(
  parameter int LONG_TICKS   = 12000000,
  parameter int DOUBLE_TICKS = 3000000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  input  logic       evt_ready,
  input  logic       ovr_clr,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS1   = 2'd1,
    WAIT2    = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [1:0] CODE_SHORT  = 2'b00;
  localparam logic [1:0] CODE_LONG   = 2'b01;
  localparam logic [1:0] CODE_DOUBLE = 2'b10;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             btn_q;
  logic             rise;
  logic             fall;
  logic             emit;
  logic [1:0]       emit_code;
  logic             xfer;
  logic             load;
  logic             drop;

  // btn_q resets low, so a level already high at reset release reads as a rise.
  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      btn_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      btn_q <= btn_level;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    emit      = 1'b0;
    emit_code = CODE_SHORT;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
        end
      end
      PRESS1: begin
        if (!btn_level) begin
          state_nxt = WAIT2;
        end else if (cnt == LONG_LAST) begin
          emit      = 1'b1;
          emit_code = CODE_LONG;
          state_nxt = WAIT_REL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT2: begin
        // A second press wins over a timeout landing in the same cycle.
        if (rise) begin
          emit      = 1'b1;
          emit_code = CODE_DOUBLE;
          state_nxt = WAIT_REL;
        end else if (cnt == DOUBLE_LAST) begin
          emit      = 1'b1;
          emit_code = CODE_SHORT;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (fall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full register accepts a new event only in the cycle it is being drained.
  assign xfer = evt_valid & evt_ready;
  assign load = emit & (~evt_valid | xfer);
  assign drop = emit & evt_valid & ~xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid   <= 1'b0;
      evt_code    <= CODE_SHORT;
      evt_overrun <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= emit_code;
      end else if (xfer) begin
        evt_valid <= 1'b0;
      end
      if (drop) begin
        evt_overrun <= 1'b1;
      end else if (ovr_clr) begin
        evt_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed gestures with literal expectations,
// then randomized gestures checked every cycle against a timestamp-based model.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int D = 4;

  localparam logic [1:0] SHORT  = 2'b00;
  localparam logic [1:0] LONG   = 2'b01;
  localparam logic [1:0] DOUBLE = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_level;
  logic       evt_ready;
  logic       ovr_clr;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_overrun;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_TICKS  (L),
    .DOUBLE_TICKS(D),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_level  (btn_level),
    .evt_ready  (evt_ready),
    .ovr_clr    (ovr_clr),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_overrun(evt_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gesture model: a phase plus the timestamp at which it began, driven by
  // the durations in the rules rather than by a step counter.
  localparam int PH_IDLE = 0, PH_DOWN = 1, PH_UP = 2, PH_HELD = 3;
  int         m_phase, m_t0, m_now;
  bit         m_prev, m_valid, m_ovr, m_emit, m_vold, m_xfer;
  logic [1:0] m_code, m_ecode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_t0 = 0; m_now = 0;
      m_prev = 0; m_valid = 0; m_ovr = 0; m_code = SHORT;
    end else begin
      m_emit = 0; m_ecode = SHORT;
      case (m_phase)
        PH_IDLE: if (btn_level && !m_prev) begin m_phase = PH_DOWN; m_t0 = m_now; end
        PH_DOWN:
          if (!btn_level) begin m_phase = PH_UP; m_t0 = m_now; end
          else if (m_now - m_t0 == L) begin m_emit = 1; m_ecode = LONG; m_phase = PH_HELD; end
        PH_UP:
          if (btn_level) begin m_emit = 1; m_ecode = DOUBLE; m_phase = PH_HELD; end
          else if (m_now - m_t0 == D) begin m_emit = 1; m_ecode = SHORT; m_phase = PH_IDLE; end
        default: if (!btn_level) m_phase = PH_IDLE;
      endcase
      m_prev = btn_level;
      m_now++;
      m_vold = m_valid;
      m_xfer = m_vold && evt_ready;
      if (m_emit && (!m_vold || m_xfer)) begin m_valid = 1; m_code = m_ecode; end
      else if (m_xfer) m_valid = 0;
      if (m_emit && m_vold && !m_xfer) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("evt_valid", evt_valid, m_valid);
      check("evt_code", evt_code, m_code);
      check("evt_overrun", evt_overrun, m_ovr);
    end
  end

  // Transfer log with posedge stamps, for the hand-computed expectations.
  int unsigned cyc = 0;
  logic [1:0]  got[$];
  int unsigned got_t[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && evt_valid && evt_ready) begin
      got.push_back(evt_code);
      got_t.push_back(cyc);
    end
  end

  task automatic hold(input logic lvl, input int n);
    btn_level = lvl;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_log();
    got.delete();
    got_t.delete();
  endtask

  task automatic expect_one(input string name, input logic [1:0] code, input int dt,
                            input int unsigned t0);
    check({name, " count"}, got.size(), 1);
    check({name, " code"}, (got.size() > 0) ? 32'(got[0]) : 32'hFF, 32'(code));
    if (dt >= 0)
      check({name, " latency"}, (got_t.size() > 0) ? got_t[0] - t0 : 32'hFFFF, dt);
  endtask

  int unsigned t0;
  int          seg;

  initial begin
    rst_n = 1'b0; btn_level = 1'b1; evt_ready = 1'b1; ovr_clr = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    check("rst valid", evt_valid, 0);
    check("rst code", evt_code, 0);
    check("rst overrun", evt_overrun, 0);
    chk_en = 1'b1;

    // 1: level high at reset release counts as a press; held 12 -> one LONG
    clear_log();
    rst_n = 1'b1;
    hold(1, 12); hold(0, 10);
    expect_one("t1", LONG, -1, 0);

    // 2: short press -> SHORT registered 4 cycles after the fall is seen
    clear_log(); t0 = cyc;
    hold(1, 3); hold(0, 12);
    expect_one("t2", SHORT, 8, t0);

    // 3: long hold -> LONG once, nothing on release
    clear_log(); t0 = cyc;
    hold(1, 20); hold(0, 10);
    expect_one("t3", LONG, 9, t0);

    // 4: double press -> DOUBLE one cycle after the second rise
    clear_log(); t0 = cyc;
    hold(1, 2); hold(0, 2); hold(1, 5); hold(0, 12);
    expect_one("t4", DOUBLE, 5, t0);

    // 5: consumer stalled -> second event dropped, overrun sticky until cleared
    clear_log();
    evt_ready = 1'b0;
    hold(1, 3); hold(0, 8);
    hold(1, 12); hold(0, 4);
    check("t5 valid held", evt_valid, 1);
    check("t5 code kept", evt_code, SHORT);
    check("t5 overrun", evt_overrun, 1);
    ovr_clr = 1'b1; hold(0, 1); ovr_clr = 1'b0;
    check("t5 overrun cleared", evt_overrun, 0);
    evt_ready = 1'b1; hold(0, 1);
    check("t5 valid dropped", evt_valid, 0);
    expect_one("t5", SHORT, -1, 0);

    // 6: reset mid-press discards the gesture; post-reset hold gives LONG only
    hold(1, 6);
    clear_log();
    rst_n = 1'b0; hold(1, 2);
    rst_n = 1'b1;
    hold(1, 10); hold(0, 10);
    expect_one("t6", LONG, -1, 0);

    // Random gestures with run lengths around both thresholds
    for (seg = 0; seg < 500; seg++) begin
      btn_level = ~btn_level;
      for (int i = $urandom_range(1, 12); i > 0; i--) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        ovr_clr   = ($urandom_range(0, 15) == 0);
        rst_n     = ($urandom_range(0, 399) != 0);
        @(negedge clk); #1;
      end
    end
    rst_n = 1'b1; ovr_clr = 1'b0; evt_ready = 1'b1;
    hold(0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
